sevenseg_scan_ctrl: RTL

- Time-multiplexes a 4-digit common-anode seven-segment display.
- Uses the display-rate tick from the clock divider.
- Steps one digit per tick rising edge and inserts a blank guard interval between digits to prevent ghosting.
- Latches display data once per full scan so digits never tear; supports leading-zero suppression and per-digit blink.
- Sits between the game score/state logic and the board's anode/segment pins.

---
 rtl/sevenseg_scan_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sevenseg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode seven-segment display.
// One digit per tick rise, blank guard between digits, frame-latched data.
module sevenseg_scan_ctrl #(
  parameter int unsigned GUARD_CYC   = 16,
  parameter int unsigned BLINK_SCANS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_i,
  input  logic [15:0] value_i,
  input  logic [3:0]  dp_in_i,
  input  logic [3:0]  blink_en_i,
  input  logic        blank_lz_i,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic        frame_start_o
);

  localparam int unsigned GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam int unsigned BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

  typedef enum logic [1:0] {IDLE, GUARD, DRIVE} state_t;

  state_t        state_q;
  logic          tick_prev_q;
  logic [1:0]    digit_q;
  logic [GW-1:0] guard_q;
  logic [15:0]   value_sh_q;
  logic [3:0]    dp_sh_q;
  logic [3:0]    blink_sh_q;
  logic          lz_sh_q;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_phase_q;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;
  logic          frame_start_q;

  logic       tick_rise;
  logic [1:0] digit_d;
  logic [3:0] nibble;
  logic       upper_zero;
  logic       blanked;
  logic [3:0] an_d;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign tick_rise = tick_i & ~tick_prev_q;
  assign digit_d   = digit_q + 2'd1;
  assign nibble    = value_sh_q[{digit_q, 2'b00} +: 4];

  // Leading-zero test: this digit and every digit above it are zero; digit 0 exempt.
  always_comb begin
    upper_zero = 1'b0;
    case (digit_q)
      2'd1:    upper_zero = (value_sh_q[15:4] == 12'h000);
      2'd2:    upper_zero = (value_sh_q[15:8] == 8'h00);
      2'd3:    upper_zero = (value_sh_q[15:12] == 4'h0);
      default: upper_zero = 1'b0;
    endcase
  end

  assign blanked = (blink_sh_q[digit_q] & blink_phase_q) | (lz_sh_q & upper_zero);
  assign an_d    = blanked ? 4'hF : ~(4'b0001 << digit_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      tick_prev_q   <= 1'b0;
      digit_q       <= 2'd3;
      guard_q       <= '0;
      value_sh_q    <= '0;
      dp_sh_q       <= '0;
      blink_sh_q    <= '0;
      lz_sh_q       <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      an_q          <= 4'hF;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      tick_prev_q   <= tick_i;
      frame_start_q <= 1'b0;
      if (tick_rise) begin
        // A rise always advances and restarts the guard, even mid-guard.
        digit_q <= digit_d;
        guard_q <= GW'(GUARD_CYC - 1);
        an_q    <= 4'hF;
        seg_q   <= 7'h7F;
        dp_q    <= 1'b1;
        state_q <= GUARD;
        if (digit_d == 2'd0) begin
          value_sh_q    <= value_i;
          dp_sh_q       <= dp_in_i;
          blink_sh_q    <= blink_en_i;
          lz_sh_q       <= blank_lz_i;
          frame_start_q <= 1'b1;
          if (blink_cnt_q == BW'(BLINK_SCANS - 1)) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
          end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
          end
        end
      end else begin
        case (state_q)
          IDLE: begin
            an_q  <= 4'hF;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
          end
          GUARD: begin
            if (guard_q == '0) begin
              state_q <= DRIVE;
              an_q    <= an_d;
              seg_q   <= hex7(nibble);
              dp_q    <= ~dp_sh_q[digit_q];
            end else begin
              guard_q <= guard_q - 1'b1;
            end
          end
          DRIVE: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign an_o          = an_q;
  assign seg_o         = seg_q;
  assign dp_o          = dp_q;
  assign frame_start_o = frame_start_q;

endmodule
